// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch stage: advance-mode encodings
// driven by the control FSM, instruction field positions and fetch states.
package instr_fetch_pkg;

    typedef logic [1:0] load_en_t;

    localparam load_en_t INSTR_PTR_LOAD_EN_FALSE = 2'd0;
    localparam load_en_t INSTR_PTR_LOAD_EN_TRUE  = 2'd1;
    localparam load_en_t INSTR_PTR_LOAD_EN_ALU   = 2'd2;

    localparam logic [7:0] NOP_OPCODE_DEF    = 8'h00;
    localparam int         OPCODE_LSB_DEF    = 120;
    localparam int         JUMP_ADDR_LSB_DEF = 88;

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

endpackage

// File: rtl/instr_fetch.sv
// Program counter and fetch stage: issues one read at a time to the
// synchronous command memory and holds the fetched word for the control FSM.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int         ADDR_W           = 8,
    parameter int         INSTR_W          = 128,
    parameter int         MEM_READ_LATENCY = 2,
    parameter int         OPCODE_LSB       = OPCODE_LSB_DEF,
    parameter int         JUMP_ADDR_LSB    = JUMP_ADDR_LSB_DEF,
    parameter logic [7:0] NOP_OPCODE       = NOP_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_ptr_en,
    input  logic [1:0]         instr_ptr_load_en,
    input  logic               alu_result_lsb,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rd_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [7:0]         opcode,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               err_early_adv
);

    localparam int CNT_W = (MEM_READ_LATENCY < 2) ? 1 : $clog2(MEM_READ_LATENCY + 1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  jump_addr;
    logic [ADDR_W-1:0]  next_pc;

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign jump_addr = instr_q[JUMP_ADDR_LSB +: ADDR_W];

    // Reserved encoding 3 falls back to a plain increment.
    always_comb begin
        next_pc = pc_inc;
        case (instr_ptr_load_en)
            INSTR_PTR_LOAD_EN_FALSE: next_pc = pc_inc;
            INSTR_PTR_LOAD_EN_TRUE:  next_pc = jump_addr;
            INSTR_PTR_LOAD_EN_ALU:   next_pc = alu_result_lsb ? jump_addr : pc_inc;
            default:                 next_pc = pc_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            ST_ISSUE: begin
                cnt_d   = CNT_W'(MEM_READ_LATENCY);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    instr_d = mem_rd_data;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (instr_ptr_en) begin
                    pc_d    = next_pc;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
        if (instr_ptr_en && (state_q != ST_VALID)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ISSUE;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    // The opcode is masked so the FSM sees a harmless NOP while a fetch is in flight.
    always_comb begin
        instr_out = instr_q;
        if (!instr_valid) begin
            instr_out[OPCODE_LSB +: 8] = NOP_OPCODE;
        end
    end

    assign instr_valid   = (state_q == ST_VALID);
    assign mem_rd_en     = (state_q == ST_ISSUE) && !reset;
    assign mem_addr      = pc_q;
    assign opcode        = instr_out[OPCODE_LSB +: 8];
    assign pc            = pc_q;
    assign err_early_adv = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a pipelined memory model with hand-picked
// jump targets walks the PC through increment, jump, conditional and wrap cases.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 128;
    localparam int L       = 2;
    localparam logic [INSTR_W-1:0] POISON = {8'hEE, 120'h0BAD};

    logic               clk = 1'b0;
    logic               reset;
    logic               instr_ptr_en;
    logic [1:0]         instr_ptr_load_en;
    logic               alu_result_lsb;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rd_data;
    logic [INSTR_W-1:0] instr_out;
    logic [7:0]         opcode;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               err_early_adv;

    logic [INSTR_W-1:0] mem [256];
    logic [INSTR_W-1:0] pipe [L];

    int err_cnt = 0;
    int chk_cnt = 0;

    instr_fetch #(
        .ADDR_W(ADDR_W),
        .INSTR_W(INSTR_W),
        .MEM_READ_LATENCY(L),
        .OPCODE_LSB(120),
        .JUMP_ADDR_LSB(88),
        .NOP_OPCODE(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .instr_ptr_en(instr_ptr_en),
        .instr_ptr_load_en(instr_ptr_load_en),
        .alu_result_lsb(alu_result_lsb),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .instr_out(instr_out),
        .opcode(opcode),
        .instr_valid(instr_valid),
        .pc(pc),
        .err_early_adv(err_early_adv)
    );

    always #5 clk = ~clk;

    // Read data appears L cycles after the strobe; idle slots carry a poison word.
    always @(posedge clk) begin
        pipe[0] <= mem_rd_en ? mem[mem_addr] : POISON;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rd_data = pipe[L-1];

    function automatic logic [7:0] jumpField(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h05;
            8'h01:   return 8'h01;
            8'h05:   return 8'h40;
            8'h40:   return 8'hFF;
            default: return 8'h05;
        endcase
    endfunction

    function automatic logic [INSTR_W-1:0] memWord(input logic [7:0] a);
        logic [INSTR_W-1:0] w;
        w          = '0;
        w[127:120] = a + 8'h20;
        w[95:88]   = jumpField(a);
        w[31:0]    = {24'hC0DE00, a};
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [INSTR_W-1:0] got,
                               input logic [INSTR_W-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] load, input logic alu);
        instr_ptr_en      = en;
        instr_ptr_load_en = load;
        alu_result_lsb    = alu;
    endtask

    // Called right after reset release; checks cycles 0..L+1 of the fetch of address 0.
    task automatic checkBoot(input string tag);
        logic [7:0] exp_op;
        exp_op = 8'h20;
        @(negedge clk);
        checkOutput({tag, "_c0_rd"}, mem_rd_en, 1);
        checkOutput({tag, "_c0_addr"}, mem_addr, 0);
        checkOutput({tag, "_c0_valid"}, instr_valid, 0);
        checkOutput({tag, "_c0_nop"}, opcode, 8'h00);
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            checkOutput({tag, "_wait_rd"}, mem_rd_en, 0);
            checkOutput({tag, "_wait_valid"}, instr_valid, 0);
            checkOutput({tag, "_wait_nop"}, opcode, 8'h00);
        end
        @(negedge clk);
        checkOutput({tag, "_valid"}, instr_valid, 1);
        checkOutput({tag, "_opcode"}, opcode, exp_op);
        checkOutput({tag, "_pc"}, pc, 0);
        checkOutput({tag, "_instr"}, instr_out, memWord(8'h00));
    endtask

    // Must be entered at a negedge with instr_valid high.
    task automatic advance(input string tag, input logic [1:0] load, input logic alu,
                           input logic [7:0] exp_pc);
        logic [7:0] exp_op;
        exp_op = exp_pc + 8'h20;
        applyStimulus(1'b1, load, alu);
        @(negedge clk);
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkOutput({tag, "_pc"}, pc, exp_pc);
        checkOutput({tag, "_rd"}, mem_rd_en, 1);
        checkOutput({tag, "_addr"}, mem_addr, exp_pc);
        checkOutput({tag, "_drop"}, instr_valid, 0);
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            checkOutput({tag, "_single_rd"}, mem_rd_en, 0);
            checkOutput({tag, "_still_low"}, instr_valid, 0);
        end
        @(negedge clk);
        checkOutput({tag, "_valid"}, instr_valid, 1);
        checkOutput({tag, "_opcode"}, opcode, exp_op);
        checkOutput({tag, "_instr"}, instr_out, memWord(exp_pc));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = memWord(8'(a));
        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_valid", instr_valid, 0);
        checkOutput("rst_rd", mem_rd_en, 0);
        checkOutput("rst_opcode", opcode, 8'h00);
        checkOutput("rst_err", err_early_adv, 0);
        checkOutput("rst_instr", instr_out, 0);

        @(posedge clk);
        #1 reset = 1'b0;
        checkBoot("boot");

        advance("jmp0", 2'd1, 1'b0, 8'h05);
        advance("inc5", 2'd0, 1'b0, 8'h06);
        advance("jmp6", 2'd1, 1'b0, 8'h05);
        advance("alu0", 2'd2, 1'b0, 8'h06);
        advance("jmp6b", 2'd1, 1'b0, 8'h05);
        advance("alu1", 2'd2, 1'b1, 8'h40);
        advance("jmp40", 2'd1, 1'b0, 8'hFF);
        advance("wrap", 2'd0, 1'b0, 8'h00);
        advance("ld3", 2'd3, 1'b0, 8'h01);
        advance("self", 2'd1, 1'b0, 8'h01);
        advance("inc1", 2'd0, 1'b0, 8'h02);

        // Advance requests while the fetch is still in flight must be ignored.
        applyStimulus(1'b1, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("early_pc_a", pc, 8'h03);
        checkOutput("early_err_a", err_early_adv, 0);
        applyStimulus(1'b1, 2'd1, 1'b0);
        @(negedge clk);
        checkOutput("early_pc_b", pc, 8'h03);
        checkOutput("early_err_b", err_early_adv, 1);
        checkOutput("early_valid", instr_valid, 0);
        @(negedge clk);
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkOutput("early_pc_c", pc, 8'h03);
        @(negedge clk);
        checkOutput("early_back", instr_valid, 1);
        checkOutput("early_opcode", opcode, 8'h23);
        checkOutput("early_pc_d", pc, 8'h03);
        advance("inc3", 2'd0, 1'b0, 8'h04);
        checkOutput("err_sticky", err_early_adv, 1);

        // Reset lands mid-WAIT; the read of address 5 returns during reset.
        applyStimulus(1'b1, 2'd0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkOutput("mid_pc", pc, 8'h05);
        checkOutput("mid_rd", mem_rd_en, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_pc", pc, 0);
        checkOutput("mid_rst_valid", instr_valid, 0);
        checkOutput("mid_rst_rd", mem_rd_en, 0);
        checkOutput("mid_rst_err", err_early_adv, 0);
        checkOutput("mid_rst_nop", opcode, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        checkBoot("reboot");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction pointer and fetch stage directly upstream of the processor control FSM. Holds the program counter and issues reads to the synchronous command memory. Presents the fetched instruction word, whose opcode the control FSM decodes. Consumes the control FSM's instr_ptr_en / instr_ptr_load_en outputs to advance by incrementing, jumping, or conditionally jumping on the ALU result.

Parameters:
ADDR_W, 8, instruction memory address width (PC width)
INSTR_W, 128, instruction word width
MEM_READ_LATENCY, 2, cycles from mem_rd_en to valid mem_rd_data (>=1)
OPCODE_LSB, 120, LSB of the 8-bit opcode field within the instruction word
JUMP_ADDR_LSB, 88, LSB of the ADDR_W-bit jump target field
NOP_OPCODE, 8'h00, opcode driven while no instruction is valid (decodes to the FSM default: stay in INIT, no side effects)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
instr_ptr_en  in  1  advance request from control FSM
instr_ptr_load_en  in  2  0=increment, 1=jump unconditional, 2=jump if alu_result_lsb
alu_result_lsb  in  1  ALU compare result bit 0
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rd_data  in  INSTR_W  memory read data
instr_out  out  INSTR_W  current instruction (opcode field forced to NOP_OPCODE when !instr_valid)
opcode  out  8  instr_out opcode field, convenience copy
instr_valid  out  1  instr_out holds the instruction at pc
pc  out  ADDR_W  current program counter
err_early_adv  out  1  sticky: instr_ptr_en seen while !instr_valid

Behaviour:
- Reset values: pc=0, instr_valid=0, mem_rd_en=0, instr register=0, opcode=NOP_OPCODE, err_early_adv=0. state=ISSUE.
- States:
  - ISSUE: mem_rd_en=1, mem_addr=pc; load wait counter with MEM_READ_LATENCY; go to WAIT.
  - WAIT: decrement counter each cycle. In the cycle the counter reaches 1, capture mem_rd_data into the instruction register and go to VALID.
  - VALID: instr_valid=1. On instr_ptr_en=1, update pc per load_en and go to ISSUE. Otherwise hold.
- Latency:
  - Read issued in cycle T; capture at end of cycle T+L; instr_valid high from T+L+1.
  - Advance accepted in cycle A; instr_valid low from A+1; read issued in A+1; valid again at A+L+2.
  - First valid after reset deassert (cycle 0 = first cycle out of reset): cycle L+1.
- Next PC, evaluated only in VALID with instr_ptr_en=1:
  - load_en=0: pc+1.
  - load_en=1: jump field = instr_reg[JUMP_ADDR_LSB +: ADDR_W].
  - load_en=2: jump field if alu_result_lsb=1, else pc+1.
  - load_en=3: treated as 0.
- Increment wraps modulo 2^ADDR_W (max -> 0), no flag.
- instr_ptr_en while in ISSUE/WAIT: ignored (pc unchanged); err_early_adv sets and stays set until reset.
- Jump to the current pc is legal: the same address is refetched.
- mem_rd_en is a single-cycle pulse per fetch; never more than one read outstanding.
- Reset mid-WAIT: outstanding read abandoned; its returning data is never captured, because capture timing restarts from the new ISSUE.
- alu_result_lsb is sampled only in the accept cycle; its value at other times is don't-care.

Decomposition:
- Shared package/include holds:
  - INSTR_PTR_LOAD_EN_FALSE=0, INSTR_PTR_LOAD_EN_TRUE=1, INSTR_PTR_LOAD_EN_ALU=2 (same encodings the control FSM drives);
  - NOP opcode; opcode and jump-field bit positions;
  - fetch state encodings.
- No sub-module needed. The latency counter stays inline; the module is a single FSM plus datapath.

Test Plan:
- Reset with L=2, mem[0]=opcode 0x20 -> mem_rd_en pulse addr 0 in cycle 0; instr_valid=1, opcode=0x20 in cycle 3; opcode=NOP_OPCODE in cycles 0-2.
- Valid at pc=5, instr_ptr_en=1, load_en=0 -> pc=6, single read of addr 6 next cycle, instr_valid low for L+1 cycles.
- pc=5, load_en=1, jump field=0x40 -> pc=0x40, read addr 0x40; load_en=2 with alu_result_lsb=0 -> pc=6, with 1 -> pc=0x40.
- pc=0xFF (ADDR_W=8), load_en=0 -> pc=0x00, read addr 0.
- instr_ptr_en=1 during WAIT -> pc unchanged, err_early_adv=1 and still 1 after the next valid advance.
- Reset asserted mid-WAIT with stale data at the old capture cycle -> pc=0, stale data not captured, mem[0] valid L+1 cycles after reset release.
